memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 151 +++++++++++++++
 tb/tb_memory_stage.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory stage of a five-stage RISC-V pipeline: holds one instruction, drives a
// req/ack data-memory port for loads and stores, and formats store and load data.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_to_m_valid,
  output logic        m_allow_in,
  input  logic        w_allow_in,
  output logic        m_to_w_valid,
  output logic        m_valid,
  input  logic [31:0] e_valE,
  input  logic [6:0]  E_opcode,
  input  logic [9:0]  E_funct,
  input  logic [31:0] E_val2,
  input  logic [4:0]  E_rd,
  input  logic [31:0] E_default_pc,
  input  logic [31:0] E_cur_pc,
  input  logic [31:0] E_instr,
  input  logic [31:0] E_pred_pc,
  input  logic        E_commit,
  output logic [31:0] M_valE,
  output logic [6:0]  M_opcode,
  output logic [9:0]  M_funct,
  output logic [31:0] M_val2,
  output logic [4:0]  M_rd,
  output logic [31:0] M_default_pc,
  output logic [31:0] M_cur_pc,
  output logic [31:0] M_instr,
  output logic [31:0] M_pred_pc,
  output logic        M_commit,
  output logic [31:0] m_valM,
  output logic        m_misalign,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state, state_nxt;
  logic        is_load, is_store, is_mem, acc, m_ready_go;
  logic [2:0]  funct3;
  logic [1:0]  byte_off;
  logic [31:0] rdata_q;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign funct3   = M_funct[2:0];
  assign byte_off = M_valE[1:0];
  assign is_load  = (M_opcode == OP_LOAD);
  assign is_store = (M_opcode == OP_STORE);
  assign is_mem   = is_load | is_store;

  assign m_misalign = m_valid & is_mem &
                      (((funct3[1:0] == 2'b01) & byte_off[0]) |
                       ((funct3[1:0] == 2'b10) & (byte_off != 2'b00)));

  assign acc          = m_valid & is_mem & ~m_misalign;
  assign dmem_req     = acc & ((state == IDLE) | (state == WAIT));
  assign m_ready_go   = ~acc | (state == HOLD);
  assign m_allow_in   = ~m_valid | (m_ready_go & w_allow_in);
  assign m_to_w_valid = m_valid & m_ready_go;

  // Request fields come only from M_* registers, which are frozen while the request waits.
  assign dmem_addr = {M_valE[31:2], 2'b00};
  assign dmem_we   = is_store;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    dmem_wdata = M_val2;
    dmem_wstrb = 4'b1111;
    case (funct3)
      3'b000: begin
        dmem_wdata = {4{M_val2[7:0]}};
        dmem_wstrb = 4'b0001 << byte_off;
      end
      3'b001: begin
        dmem_wdata = {2{M_val2[15:0]}};
        dmem_wstrb = byte_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_half = byte_off[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (byte_off)
      2'd0:    sel_byte = rdata_q[7:0];
      2'd1:    sel_byte = rdata_q[15:8];
      2'd2:    sel_byte = rdata_q[23:16];
      default: sel_byte = rdata_q[31:24];
    endcase
    m_valM = '0;
    if (is_load & ~m_misalign) begin
      case (funct3)
        3'b000:  m_valM = {{24{sel_byte[7]}}, sel_byte};
        3'b001:  m_valM = {{16{sel_half[15]}}, sel_half};
        3'b100:  m_valM = {24'd0, sel_byte};
        3'b101:  m_valM = {16'd0, sel_half};
        default: m_valM = rdata_q;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dmem_req) state_nxt = dmem_ack ? HOLD : WAIT;
      WAIT:    if (dmem_ack) state_nxt = HOLD;
      HOLD:    if (w_allow_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      if (m_allow_in) m_valid <= e_to_m_valid;
      state <= state_nxt;
      if (dmem_req & dmem_ack) rdata_q <= dmem_rdata;
    end
  end

  // NOTE: pipeline payload is qualified by m_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (m_allow_in & e_to_m_valid) begin
      M_valE       <= e_valE;
      M_opcode     <= E_opcode;
      M_funct      <= E_funct;
      M_val2       <= E_val2;
      M_rd         <= E_rd;
      M_default_pc <= E_default_pc;
      M_cur_pc     <= E_cur_pc;
      M_instr      <= E_instr;
      M_pred_pc    <= E_pred_pc;
      M_commit     <= E_commit;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a transaction-level model.
module tb_memory_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 0;
  logic        rst;
  logic        e_to_m_valid, m_allow_in, w_allow_in, m_to_w_valid, m_valid;
  logic [31:0] e_valE, E_val2, E_default_pc, E_cur_pc, E_instr, E_pred_pc;
  logic [6:0]  E_opcode;
  logic [9:0]  E_funct;
  logic [4:0]  E_rd;
  logic        E_commit;
  logic [31:0] M_valE, M_val2, M_default_pc, M_cur_pc, M_instr, M_pred_pc;
  logic [6:0]  M_opcode;
  logic [9:0]  M_funct;
  logic [4:0]  M_rd;
  logic        M_commit;
  logic [31:0] m_valM;
  logic        m_misalign;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  int checks = 0;
  int errors = 0;

  memory_stage dut (
    .clk(clk), .rst(rst),
    .e_to_m_valid(e_to_m_valid), .m_allow_in(m_allow_in),
    .w_allow_in(w_allow_in), .m_to_w_valid(m_to_w_valid), .m_valid(m_valid),
    .e_valE(e_valE), .E_opcode(E_opcode), .E_funct(E_funct), .E_val2(E_val2),
    .E_rd(E_rd), .E_default_pc(E_default_pc), .E_cur_pc(E_cur_pc),
    .E_instr(E_instr), .E_pred_pc(E_pred_pc), .E_commit(E_commit),
    .M_valE(M_valE), .M_opcode(M_opcode), .M_funct(M_funct), .M_val2(M_val2),
    .M_rd(M_rd), .M_default_pc(M_default_pc), .M_cur_pc(M_cur_pc),
    .M_instr(M_instr), .M_pred_pc(M_pred_pc), .M_commit(M_commit),
    .m_valM(m_valM), .m_misalign(m_misalign),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic [31:0] valE;
    logic [6:0]  opcode;
    logic [9:0]  funct;
    logic [31:0] val2;
    logic [4:0]  rd;
    logic [31:0] dpc, cpc, instr, ppc;
    logic        commit;
  } instr_t;

  instr_t      cur;
  logic        mv = 0;      // an instruction occupies the stage
  logic        got = 0;     // its memory response has been received
  logic [31:0] word = '0;   // the received word
  bit          model_ok = 0;

  function automatic int f_off();
    return int'(cur.valE[1:0]);
  endfunction

  function automatic logic f_load();
    return cur.opcode == OP_LOAD;
  endfunction

  function automatic logic f_mem();
    return mv && (cur.opcode == OP_LOAD || cur.opcode == OP_STORE);
  endfunction

  function automatic logic f_mis();
    int w;
    w = (cur.funct[1:0] == 2'b01) ? 2 : (cur.funct[1:0] == 2'b10) ? 4 : 1;
    return f_mem() && (f_off() % w != 0);
  endfunction

  function automatic logic f_acc();   return f_mem() && !f_mis(); endfunction
  function automatic logic f_req();   return f_acc() && !got; endfunction
  function automatic logic f_ready(); return !f_acc() || got; endfunction
  function automatic logic f_to_w();  return mv && f_ready(); endfunction
  function automatic logic f_allow(); return !mv || (f_ready() && w_allow_in); endfunction

  function automatic logic [31:0] f_valM();
    logic [7:0]  b;
    logic [15:0] h;
    if (!f_load() || f_mis()) return 32'd0;
    b = 8'(word >> (8 * f_off()));
    h = 16'(word >> (16 * (f_off() / 2)));
    case (cur.funct[2:0])
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata();
    case (cur.funct[2:0])
      3'd0:    return {4{cur.val2[7:0]}};
      3'd1:    return {2{cur.val2[15:0]}};
      default: return cur.val2;
    endcase
  endfunction

  function automatic logic [3:0] f_wstrb();
    case (cur.funct[2:0])
      3'd0:    return 4'(1 << f_off());
      3'd1:    return (f_off() >= 2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mv       <= 1'b0;
      got      <= 1'b0;
      word     <= '0;
      model_ok <= 1'b1;
    end else if (model_ok) begin
      if (f_req() && dmem_ack) begin
        got  <= 1'b1;
        word <= dmem_rdata;
      end else if (got && w_allow_in) begin
        got <= 1'b0;
      end
      if (f_allow()) begin
        mv <= e_to_m_valid;
        if (e_to_m_valid)
          cur <= '{valE: e_valE, opcode: E_opcode, funct: E_funct, val2: E_val2,
                   rd: E_rd, dpc: E_default_pc, cpc: E_cur_pc, instr: E_instr,
                   ppc: E_pred_pc, commit: E_commit};
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("m_valid", m_valid, mv);
      check("dmem_req", dmem_req, f_req());
      check("m_to_w_valid", m_to_w_valid, f_to_w());
      check("m_allow_in", m_allow_in, f_allow());
      check("m_misalign", m_misalign, f_mis());
      if (f_req()) begin
        check("dmem_addr", dmem_addr, {cur.valE[31:2], 2'b00});
        check("dmem_we", dmem_we, cur.opcode == OP_STORE);
        if (cur.opcode == OP_STORE) begin
          check("dmem_wdata", dmem_wdata, f_wdata());
          check("dmem_wstrb", dmem_wstrb, f_wstrb());
        end
      end
      if (f_to_w()) check("m_valM", m_valM, f_valM());
      if (mv) begin
        check("M_valE", M_valE, cur.valE);
        check("M_opcode", M_opcode, cur.opcode);
        check("M_funct", M_funct, cur.funct);
        check("M_val2", M_val2, cur.val2);
        check("M_rd", M_rd, cur.rd);
        check("M_default_pc", M_default_pc, cur.dpc);
        check("M_cur_pc", M_cur_pc, cur.cpc);
        check("M_instr", M_instr, cur.instr);
        check("M_pred_pc", M_pred_pc, cur.ppc);
        check("M_commit", M_commit, cur.commit);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input logic [6:0] op, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] v2);
    e_to_m_valid = 1'b1;
    E_opcode     = op;
    E_funct      = {7'($urandom), f3};
    e_valE       = addr;
    E_val2       = v2;
    E_rd         = 5'($urandom);
    E_default_pc = $urandom;
    E_cur_pc     = $urandom;
    E_instr      = $urandom;
    E_pred_pc    = $urandom;
    E_commit     = 1'($urandom);
  endtask

  task automatic run_lb(input logic [2:0] f3, input logic [31:0] exp_val);
    int nreq;
    nreq = 0;
    put(OP_LOAD, f3, 32'h0000_1002, 32'd0);
    tick();
    e_to_m_valid = 1'b0;
    dmem_rdata   = 32'h8899_AABB;
    for (int k = 0; k < 4; k++) begin
      dmem_ack = (k == 3);
      sample();
      if (dmem_req) nreq++;
      if (k == 0) check("lb_addr", dmem_addr, 32'h0000_1000);
      tick();
    end
    dmem_ack = 1'b0;
    check("lb_req_cycles", nreq, 4);
    sample();
    check("lb_to_w", m_to_w_valid, 1);
    check("lb_valM", m_valM, exp_val);
    check("lb_req_done", dmem_req, 0);
    tick();
  endtask

  initial begin
    rst = 1'b1; e_to_m_valid = 1'b0; w_allow_in = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    e_valE = '0; E_opcode = '0; E_funct = '0; E_val2 = '0; E_rd = '0; E_default_pc = '0;
    E_cur_pc = '0; E_instr = '0; E_pred_pc = '0; E_commit = 1'b0;
    tick();
    tick();
    sample();
    check("rst_m_valid", m_valid, 0);
    check("rst_req", dmem_req, 0);
    check("rst_to_w", m_to_w_valid, 0);
    rst = 1'b0;
    tick();

    // ALU op: one cycle in the stage, no memory traffic
    put(OP_ALU, 3'd0, 32'h0000_1234, 32'd0);
    tick();
    e_to_m_valid = 1'b0;
    sample();
    check("alu_to_w", m_to_w_valid, 1);
    check("alu_req", dmem_req, 0);
    check("alu_valE", M_valE, 32'h0000_1234);
    tick();
    sample();
    check("alu_occupancy", m_valid, 0);

    // LB and LBU with three wait cycles
    run_lb(3'b000, 32'hFFFF_FF99);
    run_lb(3'b100, 32'h0000_0099);

    // SH acked in the request cycle
    put(OP_STORE, 3'b001, 32'h0000_1002, 32'h0000_BEEF);
    tick();
    e_to_m_valid = 1'b0;
    dmem_ack = 1'b1;
    sample();
    check("sh_req", dmem_req, 1);
    check("sh_we", dmem_we, 1);
    check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    check("sh_wstrb", dmem_wstrb, 4'b1100);
    check("sh_to_w_early", m_to_w_valid, 0);
    tick();
    dmem_ack = 1'b0;
    sample();
    check("sh_to_w", m_to_w_valid, 1);
    check("sh_req_done", dmem_req, 0);
    tick();

    // misaligned LW passes through in one cycle
    put(OP_LOAD, 3'b010, 32'h0000_1001, 32'd0);
    tick();
    e_to_m_valid = 1'b0;
    sample();
    check("mis_flag", m_misalign, 1);
    check("mis_req", dmem_req, 0);
    check("mis_valM", m_valM, 0);
    check("mis_to_w", m_to_w_valid, 1);
    tick();
    sample();
    check("mis_occupancy", m_valid, 0);

    // load held in HOLD by writeback back-pressure
    w_allow_in = 1'b0;
    put(OP_LOAD, 3'b010, 32'h0000_2000, 32'd0);
    tick();
    e_to_m_valid = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      put(7'($urandom), 3'($urandom), $urandom, $urandom);
      dmem_rdata = $urandom;
      sample();
      check("hold_allow_in", m_allow_in, 0);
      check("hold_valM", m_valM, 32'hCAFE_F00D);
      check("hold_valE", M_valE, 32'h0000_2000);
      check("hold_opcode", M_opcode, OP_LOAD);
      check("hold_to_w", m_to_w_valid, 1);
      check("hold_req", dmem_req, 0);
      tick();
    end
    e_to_m_valid = 1'b0;
    w_allow_in = 1'b1;
    tick();
    sample();
    check("hold_release", m_valid, 0);

    // reset while WAIT, then a late ack
    put(OP_LOAD, 3'b010, 32'h0000_3000, 32'd0);
    tick();
    e_to_m_valid = 1'b0;
    sample();
    check("wait_req", dmem_req, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dmem_ack = 1'b1;
    sample();
    check("late_ack_req", dmem_req, 0);
    check("late_ack_valid", m_valid, 0);
    check("late_ack_to_w", m_to_w_valid, 0);
    tick();
    dmem_ack = 1'b0;
    put(OP_LOAD, 3'b010, 32'h0000_3004, 32'd0);
    tick();
    e_to_m_valid = 1'b0;
    sample();
    check("late_ack_idle_req", dmem_req, 1);
    check("late_ack_idle_to_w", m_to_w_valid, 0);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tick();
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 2))
        0:       put(OP_LOAD, 3'($urandom), $urandom, $urandom);
        1:       put(OP_STORE, 3'($urandom), $urandom, $urandom);
        default: put(7'($urandom), 3'($urandom), $urandom, $urandom);
      endcase
      e_to_m_valid = ($urandom_range(0, 9) < 6);
      w_allow_in   = ($urandom_range(0, 9) < 7);
      dmem_ack     = ($urandom_range(0, 9) < 4);
      dmem_rdata   = $urandom;
      tick();
    end
    rst = 1'b0;
    e_to_m_valid = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
